// File: rtl/fmul_pkg.sv
// Shared definitions for the FMUL32 unpack/exponent front end.
package fmul_pkg;

  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX  = 255;
  localparam int MANT_W   = 24;
  localparam int FRAC_W   = MANT_W - 1;

  // Bit positions inside the prev_res special-case vector
  localparam int PR_NAN  = 3;
  localparam int PR_INV  = 2;
  localparam int PR_INF  = 1;
  localparam int PR_ZERO = 0;

  // Operand class flags, exactly one (or none, for a normal number) is set
  typedef struct packed {
    logic nan;
    logic inf;
    logic denorm;
    logic zero;
  } op_class_t;

  // Classify an operand from its exponent and fraction fields
  function automatic op_class_t classify(input logic [7:0] exp_f,
                                         input logic [FRAC_W-1:0] frac_f);
    op_class_t c;
    c.zero   = (exp_f == 8'd0)   && (frac_f == '0);
    c.denorm = (exp_f == 8'd0)   && (frac_f != '0);
    c.inf    = (exp_f == 8'hFF)  && (frac_f == '0);
    c.nan    = (exp_f == 8'hFF)  && (frac_f != '0);
    return c;
  endfunction

endpackage

// File: rtl/fmul_lzc24.sv
// Combinational 24-bit leading-zero counter; an all-zero input yields 24.
module fmul_lzc24
  import fmul_pkg::*;
(
  input  logic [MANT_W-1:0] mant_i,
  output logic [4:0]        count_o
);

  logic found;

  // Scan from the MSB down, counting zeros until the first set bit
  always_comb begin
    count_o = 5'd0;
    found   = 1'b0;
    for (int i = MANT_W - 1; i >= 0; i--) begin
      if (!found) begin
        if (mant_i[i]) begin
          found = 1'b1;
        end else begin
          count_o = count_o + 5'd1;
        end
      end
    end
  end

endmodule

// File: rtl/fmul_unpack_exp.sv
// FMUL32 front end: operand unpack, special-case classification and
// pre-normalisation exponent formation, in a 2-stage valid/ready pipe.
module fmul_unpack_exp
  import fmul_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int EXP_W  = 8,
  parameter int BIAS   = EXP_BIAS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sign_res,
  output logic [MANT_W-1:0] mant_a,
  output logic [MANT_W-1:0] mant_b,
  output logic [EXP_W-1:0]  exp_res_tmp,
  output logic [3:0]        prev_res,
  output logic [EXP_W-1:0]  denorm_shift,
  output logic [1:0]        exp_condition,
  output logic [EXP_W-1:0]  leading_zero_num,
  output logic [1:0]        denorm_AB
);

  if (DATA_W != 32) begin : g_bad_width
    $error("fmul_unpack_exp: only DATA_W = 32 is supported");
  end

  // Two guard bits let the exponent sum go negative or past 255 unambiguously
  localparam int SUM_W = EXP_W + 2;
  localparam logic signed [SUM_W-1:0] E_ONE  = SUM_W'(1);
  localparam logic signed [SUM_W-1:0] E_MAXS = SUM_W'(EXP_MAX);
  localparam logic signed [SUM_W-1:0] E_BIAS = SUM_W'(BIAS);

  // ---------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------
  logic s1_valid_q, s1_valid_d;
  logic s2_valid_q, s2_valid_d;
  logic s2_advance;
  logic accept;

  assign s2_advance = !s2_valid_q || out_ready;
  assign in_ready   = !s1_valid_q || s2_advance;
  assign accept     = in_valid && in_ready;
  assign out_valid  = s2_valid_q;

  // ---------------------------------------------------------------
  // Stage 1: field split and classification
  // ---------------------------------------------------------------
  logic [EXP_W-1:0]  exp_a, exp_b;
  logic [FRAC_W-1:0] frac_a, frac_b;
  op_class_t         cls_a, cls_b;
  logic [MANT_W-1:0] new_mant_a, new_mant_b, lzc_in;
  logic [EXP_W-1:0]  new_eff_a, new_eff_b;
  logic [4:0]        lzc_count;

  logic              s1_sign_q,   s1_sign_d;
  logic [MANT_W-1:0] s1_mant_a_q, s1_mant_a_d;
  logic [MANT_W-1:0] s1_mant_b_q, s1_mant_b_d;
  logic [EXP_W-1:0]  s1_eff_a_q,  s1_eff_a_d;
  logic [EXP_W-1:0]  s1_eff_b_q,  s1_eff_b_d;
  op_class_t         s1_cls_a_q,  s1_cls_a_d;
  op_class_t         s1_cls_b_q,  s1_cls_b_d;
  logic [4:0]        s1_lzc_q,    s1_lzc_d;

  // Unpack fields, restore hidden bits and pick the operand to count zeros on
  always_comb begin
    exp_a      = op_a[DATA_W-2 -: EXP_W];
    exp_b      = op_b[DATA_W-2 -: EXP_W];
    frac_a     = op_a[FRAC_W-1:0];
    frac_b     = op_b[FRAC_W-1:0];
    cls_a      = classify(exp_a, frac_a);
    cls_b      = classify(exp_b, frac_b);
    new_mant_a = {(exp_a != '0), frac_a};
    new_mant_b = {(exp_b != '0), frac_b};
    new_eff_a  = cls_a.denorm ? EXP_W'(1) : exp_a;
    new_eff_b  = cls_b.denorm ? EXP_W'(1) : exp_b;
    lzc_in     = cls_a.denorm ? new_mant_a : new_mant_b;
  end

  fmul_lzc24 u_lzc (
    .mant_i  (lzc_in),
    .count_o (lzc_count)
  );

  // Stage 1 captures a new pair only on acceptance; otherwise it holds
  always_comb begin
    s1_valid_d  = in_ready ? in_valid : s1_valid_q;
    s1_sign_d   = s1_sign_q;
    s1_mant_a_d = s1_mant_a_q;
    s1_mant_b_d = s1_mant_b_q;
    s1_eff_a_d  = s1_eff_a_q;
    s1_eff_b_d  = s1_eff_b_q;
    s1_cls_a_d  = s1_cls_a_q;
    s1_cls_b_d  = s1_cls_b_q;
    s1_lzc_d    = s1_lzc_q;
    if (accept) begin
      s1_sign_d   = op_a[DATA_W-1] ^ op_b[DATA_W-1];
      s1_mant_a_d = new_mant_a;
      s1_mant_b_d = new_mant_b;
      s1_eff_a_d  = new_eff_a;
      s1_eff_b_d  = new_eff_b;
      s1_cls_a_d  = cls_a;
      s1_cls_b_d  = cls_b;
      s1_lzc_d    = lzc_count;
    end
  end

  // Stage 1 register with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mant_a_q <= '0;
      s1_mant_b_q <= '0;
      s1_eff_a_q  <= '0;
      s1_eff_b_q  <= '0;
      s1_cls_a_q  <= '0;
      s1_cls_b_q  <= '0;
      s1_lzc_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_mant_a_q <= s1_mant_a_d;
      s1_mant_b_q <= s1_mant_b_d;
      s1_eff_a_q  <= s1_eff_a_d;
      s1_eff_b_q  <= s1_eff_b_d;
      s1_cls_a_q  <= s1_cls_a_d;
      s1_cls_b_q  <= s1_cls_b_d;
      s1_lzc_q    <= s1_lzc_d;
    end
  end

  // ---------------------------------------------------------------
  // Stage 2: exponent arithmetic and status vectors
  // ---------------------------------------------------------------
  logic signed [SUM_W-1:0] sum_e;
  logic signed [SUM_W-1:0] shift_e;
  logic                    any_nan, any_inv, any_inf, any_zero, one_denorm;
  logic [3:0]              new_prev;
  logic [1:0]              new_cond;
  logic [EXP_W-1:0]        new_exp, new_shift, new_lzn;

  logic              s2_sign_q,  s2_sign_d;
  logic [MANT_W-1:0] s2_mant_a_q, s2_mant_a_d;
  logic [MANT_W-1:0] s2_mant_b_q, s2_mant_b_d;
  logic [EXP_W-1:0]  s2_exp_q,   s2_exp_d;
  logic [3:0]        s2_prev_q,  s2_prev_d;
  logic [EXP_W-1:0]  s2_shift_q, s2_shift_d;
  logic [1:0]        s2_cond_q,  s2_cond_d;
  logic [EXP_W-1:0]  s2_lzn_q,   s2_lzn_d;
  logic [1:0]        s2_dab_q,   s2_dab_d;

  // Special-case priority is NaN > Inf*0 > Inf > zero; each lower flag is masked
  always_comb begin
    sum_e      = $signed({2'b00, s1_eff_a_q}) + $signed({2'b00, s1_eff_b_q}) - E_BIAS;
    shift_e    = E_ONE - sum_e;
    one_denorm = s1_cls_a_q.denorm ^ s1_cls_b_q.denorm;

    any_nan  = s1_cls_a_q.nan || s1_cls_b_q.nan;
    any_inv  = !any_nan && ((s1_cls_a_q.inf && s1_cls_b_q.zero) ||
                            (s1_cls_a_q.zero && s1_cls_b_q.inf));
    any_inf  = (s1_cls_a_q.inf || s1_cls_b_q.inf) && !any_nan && !any_inv;
    any_zero = (s1_cls_a_q.zero || s1_cls_b_q.zero ||
                (s1_cls_a_q.denorm && s1_cls_b_q.denorm)) &&
               !any_nan && !any_inv && !any_inf;

    new_prev          = 4'b0000;
    new_prev[PR_NAN]  = any_nan;
    new_prev[PR_INV]  = any_inv;
    new_prev[PR_INF]  = any_inf;
    new_prev[PR_ZERO] = any_zero;

    new_cond = 2'b00;
    if ((sum_e >= E_MAXS) && (new_prev == 4'b0000)) begin
      new_cond = one_denorm ? 2'b10 : 2'b01;
    end

    new_exp   = sum_e[EXP_W-1:0];
    new_shift = '0;
    if (sum_e >= E_MAXS) begin
      new_exp = EXP_W'(EXP_MAX);
    end else if (sum_e < E_ONE) begin
      new_exp   = '0;
      new_shift = (shift_e > E_MAXS) ? EXP_W'(EXP_MAX) : shift_e[EXP_W-1:0];
    end

    new_lzn = one_denorm ? {{(EXP_W-5){1'b0}}, s1_lzc_q} : '0;
  end

  // Stage 2 loads when the pipe advances and stage 1 holds a pair
  always_comb begin
    s2_valid_d  = s2_advance ? s1_valid_q : s2_valid_q;
    s2_sign_d   = s2_sign_q;
    s2_mant_a_d = s2_mant_a_q;
    s2_mant_b_d = s2_mant_b_q;
    s2_exp_d    = s2_exp_q;
    s2_prev_d   = s2_prev_q;
    s2_shift_d  = s2_shift_q;
    s2_cond_d   = s2_cond_q;
    s2_lzn_d    = s2_lzn_q;
    s2_dab_d    = s2_dab_q;
    if (s2_advance && s1_valid_q) begin
      s2_sign_d   = s1_sign_q;
      s2_mant_a_d = s1_mant_a_q;
      s2_mant_b_d = s1_mant_b_q;
      s2_exp_d    = new_exp;
      s2_prev_d   = new_prev;
      s2_shift_d  = new_shift;
      s2_cond_d   = new_cond;
      s2_lzn_d    = new_lzn;
      s2_dab_d    = {s1_cls_b_q.denorm, s1_cls_a_q.denorm};
    end
  end

  // Stage 2 register with synchronous reset; it drives the outputs directly
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q  <= 1'b0;
      s2_sign_q   <= 1'b0;
      s2_mant_a_q <= '0;
      s2_mant_b_q <= '0;
      s2_exp_q    <= '0;
      s2_prev_q   <= '0;
      s2_shift_q  <= '0;
      s2_cond_q   <= '0;
      s2_lzn_q    <= '0;
      s2_dab_q    <= '0;
    end else begin
      s2_valid_q  <= s2_valid_d;
      s2_sign_q   <= s2_sign_d;
      s2_mant_a_q <= s2_mant_a_d;
      s2_mant_b_q <= s2_mant_b_d;
      s2_exp_q    <= s2_exp_d;
      s2_prev_q   <= s2_prev_d;
      s2_shift_q  <= s2_shift_d;
      s2_cond_q   <= s2_cond_d;
      s2_lzn_q    <= s2_lzn_d;
      s2_dab_q    <= s2_dab_d;
    end
  end

  assign sign_res         = s2_sign_q;
  assign mant_a           = s2_mant_a_q;
  assign mant_b           = s2_mant_b_q;
  assign exp_res_tmp      = s2_exp_q;
  assign prev_res         = s2_prev_q;
  assign denorm_shift     = s2_shift_q;
  assign exp_condition    = s2_cond_q;
  assign leading_zero_num = s2_lzn_q;
  assign denorm_AB        = s2_dab_q;

endmodule
